// File: rtl/calc_prog_encoder.sv
// Encodes calculator operations into 32-bit instruction words and loads them
// sequentially into instruction memory, zero-filling the rest of the region.
module calc_prog_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_funct,
    input  logic [13:0] op_immA,
    input  logic [13:0] op_immB,
    input  logic        op_last,
    output logic        wr_en,
    output logic [31:0] data_addr,
    output logic [31:0] data_in,
    output logic        busy,
    output logic        prog_done,
    output logic        overflow_err,
    output logic [15:0] word_count
);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_e;

    localparam logic [15:0] LAST_IDX = 16'(DEPTH - 1);

    state_e      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] wc_q, wc_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] slot_addr;

    assign slot_addr = BASE_ADDR + {14'b0, idx_q, 2'b00};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wc_d    = wc_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    wc_d    = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                if (op_valid) begin
                    wr_en_d = 1'b1;
                    addr_d  = slot_addr;
                    data_d  = {op_funct, 1'b0, op_immA, op_immB};
                    idx_d   = idx_q + 16'd1;
                    wc_d    = wc_q + 16'd1;
                    // Running out of slots ends the session whether or not last was seen
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        ovf_d   = !op_last;
                    end else if (op_last) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                wr_en_d = 1'b1;
                addr_d  = slot_addr;
                data_d  = '0;
                idx_d   = idx_q + 16'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    wc_d    = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wc_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wc_q    <= wc_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign op_ready     = (state_q == LOAD);
    assign wr_en        = wr_en_q;
    assign data_addr    = addr_q;
    assign data_in      = data_q;
    assign busy         = (state_q == LOAD) || (state_q == FILL) || wr_en_q;
    assign prog_done    = done_q;
    assign overflow_err = ovf_q;
    assign word_count   = wc_q;

endmodule

// File: doc/calc_prog_encoder.md
# calc_prog_encoder

Instruction encoder and program loader for the accumulator calculator. Accepts calculator operations (funct, immA, immB) over a valid/ready stream and packs each one into a 32-bit instruction word. It writes the words sequentially into instruction memory at byte addresses stepping by 4, matching the PC increment. After the final operation it zero-fills the rest of the program region and then signals completion, so the calculator core can be released from reset.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of instruction 0; must be word-aligned.
- DEPTH, 64, program region size in words; must be ≥1 and ≤65535.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  pulse; begins a load session from IDLE or DONE.
- op_valid  in  1  operation present.
- op_ready  out  1  encoder can accept an operation this cycle.
- op_funct  in  3  function code.
- op_immA  in  14  immediate A, unsigned.
- op_immB  in  14  immediate B, unsigned.
- op_last  in  1  marks the final operation of the program.
- wr_en  out  1  instruction-memory write strobe, one word per cycle.
- data_addr  out  32  write byte address.
- data_in  out  32  encoded instruction word.
- busy  out  1  session in progress or a write is pending.
- prog_done  out  1  level; the program region is fully written.
- overflow_err  out  1  level; DEPTH was reached without op_last.
- word_count  out  16  number of operation words accepted this session.

## Operation
- Encoding: data_in = {op_funct[2:0], 1'b0, op_immA[13:0], op_immB[13:0]}.
  - Bits 31:29 are funct, bit 28 is reserved 0, bits 27:14 are immA, bits 13:0 are immB.
  - Zero-fill words are 32'h0000_0000.
- Write stage: a single output register holding wr_en, data_addr and data_in. It is loaded by either an accepted operation or a fill-word generation, never both in the same cycle.
- Index idx (16 bits) is the next word slot. Write address = BASE_ADDR + 4·idx, computed modulo 2^32.
- FSM states: IDLE, LOAD, FILL, DONE.
  - IDLE: op_ready=0. start → LOAD, with idx=0, word_count=0, prog_done=0, overflow_err=0.
  - LOAD: op_ready=1. An accept (op_valid&&op_ready) loads the write stage with the encoded word at idx, then idx++ and word_count++.
    - Accept with op_last=1 and idx+1<DEPTH → FILL.
    - Accept with idx+1==DEPTH: op_last=1 → DONE; op_last=0 → DONE and overflow_err=1.
  - FILL: op_ready=0. Each cycle loads the write stage with a zero word at idx, then idx++. The cycle that generates slot DEPTH−1 → DONE.
  - DONE: op_ready=0. prog_done=1 from the cycle after the final wr_en pulse. start → LOAD, clearing prog_done and overflow_err.
- start is ignored in LOAD and FILL.
- op_valid is ignored outside LOAD.
- Operation fields are sampled only on accept.
- busy = (state is LOAD or FILL) or wr_en.

## Timing
- Reset (reset=0 at an edge): state=IDLE, idx=0.
  - All outputs are 0 in the following cycle: op_ready, wr_en, data_addr, data_in, busy, prog_done, overflow_err, word_count.
  - Reset during LOAD or FILL drops any pending write; no wr_en follows.
- Latency: an accept or fill generation at edge N gives wr_en=1 with its address and data during cycle N+1 to N+2. wr_en lasts exactly one cycle per word.
- Throughput: one word per cycle. op_ready stays high through back-to-back accepts in LOAD.
- The FILL→DONE transition and the final write overlap. prog_done rises in the cycle immediately after that last wr_en.
- With DEPTH=1, the first accept goes straight to DONE.
- Exactly DEPTH writes occur per session, at strictly increasing addresses.

## Test plan
- Encode: DEPTH=4, BASE=0, start, then op (funct=3'b101, immA=14'h0012, immB=14'h3FFF, last=1).
  - Required: wr_en at addr 0 with data 32'hA004_BFFF.
  - Then zero writes at addr 4, 8 and 12 on consecutive cycles.
  - prog_done=1 the next cycle; word_count=1.
- Back-to-back: DEPTH=8, BASE=32'h100, 8 ops with op_valid held high, last on the 8th.
  - Required: 8 consecutive wr_en at 0x100 through 0x11C; no fill; prog_done=1; overflow_err=0.
- Overflow: DEPTH=4, 4 ops all with last=0.
  - Required: op_ready falls after the 4th accept; overflow_err=1; prog_done=1; a 5th op_valid is never accepted.
- Reset mid-FILL: DEPTH=16, 1 op with last=1, reset=0 two cycles later.
  - Required: next cycle wr_en=0, busy=0, prog_done=0, and all outputs 0.
- Restart and ignored start: pulse start during FILL → no effect. After DONE, start → word_count=0, prog_done=0, op_ready=1; a new session writes again from BASE_ADDR.
